// File: rtl/mem_pkg.sv
// Shared types for mem_channel_arbiter: channel FSM encoding and lane-index width helper.
package mem_pkg;

  typedef enum logic [2:0] {
    CH_IDLE           = 3'b000,
    CH_READ_WAITING   = 3'b010,
    CH_WRITE_WAITING  = 3'b011,
    CH_READ_RELAYING  = 3'b100,
    CH_WRITE_RELAYING = 3'b101
  } channel_state_t;

  // A single lane still needs a 1-bit index.
  function automatic int consumer_idx_bits(input int num_consumers);
    return (num_consumers > 1) ? $clog2(num_consumers) : 1;
  endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Combinational lane picker: first eligible lane at or after start, wrapping modulo NUM.
module mem_rr_pick #(
  parameter int NUM   = 8,
  parameter int IDX_W = 3
) (
  input  logic [NUM-1:0]   eligible,
  input  logic [IDX_W-1:0] start,
  output logic [NUM-1:0]   onehot,
  output logic [IDX_W-1:0] index,
  output logic             found
);

  int cand;

  always_comb begin
    onehot = '0;
    index  = '0;
    found  = 1'b0;
    cand   = 0;
    for (int off = 0; off < NUM; off++) begin
      cand = int'(start) + off;
      if (cand >= NUM) cand = cand - NUM;
      if (!found && eligible[cand]) begin
        found        = 1'b1;
        onehot[cand] = 1'b1;
        index        = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_channel_arbiter.sv
// Schedules per-lane read/write requests onto NUM_CHANNELS memory channels, one FSM per channel.
// Define ARB_ROUND_ROBIN_EN for a rotating lane search start; otherwise lowest lane wins.
module mem_channel_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [ADDR_BITS*NUM_CONSUMERS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [DATA_BITS*NUM_CONSUMERS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [ADDR_BITS*NUM_CONSUMERS-1:0] consumer_write_address,
  input  logic [DATA_BITS*NUM_CONSUMERS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [ADDR_BITS*NUM_CHANNELS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [DATA_BITS*NUM_CHANNELS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [ADDR_BITS*NUM_CHANNELS-1:0]  mem_write_address,
  output logic [DATA_BITS*NUM_CHANNELS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

  localparam int IDX_W = consumer_idx_bits(NUM_CONSUMERS);

  channel_state_t       state_reg  [NUM_CHANNELS];
  channel_state_t       state_next [NUM_CHANNELS];
  logic [IDX_W-1:0]     owner_reg  [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] addr_reg   [NUM_CHANNELS];
  logic [DATA_BITS-1:0] wdata_reg  [NUM_CHANNELS];
  logic [DATA_BITS-1:0] rdata_reg  [NUM_CHANNELS];

  logic [NUM_CONSUMERS-1:0] busy_reg, busy_next;
  logic [NUM_CHANNELS-1:0][NUM_CONSUMERS-1:0] avail, pick_oh;
  logic [NUM_CHANNELS-1:0][IDX_W-1:0] pick_idx;
  logic [NUM_CHANNELS-1:0] pick_found, grant, grant_read, release_lane;
  logic [IDX_W-1:0] start_idx;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_reg, ptr_next;

  // The highest-index granting channel holds the last granted lane.
  always_comb begin
    ptr_next = ptr_reg;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (grant[c])
        ptr_next = (pick_idx[c] == IDX_W'(NUM_CONSUMERS - 1)) ? '0 : pick_idx[c] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_reg <= '0;
    else       ptr_reg <= ptr_next;
  end

  assign start_idx = ptr_reg;
`else
  assign start_idx = '0;
`endif

  assign avail[0] = (consumer_read_valid | consumer_write_valid) & ~busy_reg;

  // Lanes claimed by a lower channel are masked out before the next channel picks.
  generate
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
      mem_rr_pick #(.NUM(NUM_CONSUMERS), .IDX_W(IDX_W)) u_pick (
        .eligible (avail[gi]),
        .start    (start_idx),
        .onehot   (pick_oh[gi]),
        .index    (pick_idx[gi]),
        .found    (pick_found[gi])
      );

      assign grant[gi]      = (state_reg[gi] == CH_IDLE) && pick_found[gi];
      assign grant_read[gi] = consumer_read_valid[pick_idx[gi]];
      assign release_lane[gi] =
          ((state_reg[gi] == CH_READ_RELAYING)  && !consumer_read_valid[owner_reg[gi]]) ||
          ((state_reg[gi] == CH_WRITE_RELAYING) && !consumer_write_valid[owner_reg[gi]]);

      if (gi < NUM_CHANNELS - 1) begin : g_mask
        assign avail[gi+1] = grant[gi] ? (avail[gi] & ~pick_oh[gi]) : avail[gi];
      end

      assign mem_read_address[gi*ADDR_BITS +: ADDR_BITS]  = addr_reg[gi];
      assign mem_write_address[gi*ADDR_BITS +: ADDR_BITS] = addr_reg[gi];
      assign mem_write_data[gi*DATA_BITS +: DATA_BITS]    = wdata_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (reset) state_reg[c] <= CH_IDLE;
      else       state_reg[c] <= state_next[c];
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      state_next[c] = state_reg[c];
      case (state_reg[c])
        CH_IDLE:
          if (grant[c]) state_next[c] = grant_read[c] ? CH_READ_WAITING : CH_WRITE_WAITING;
        CH_READ_WAITING:
          if (mem_read_ready[c]) state_next[c] = CH_READ_RELAYING;
        CH_WRITE_WAITING:
          if (mem_write_ready[c]) state_next[c] = CH_WRITE_RELAYING;
        CH_READ_RELAYING, CH_WRITE_RELAYING:
          if (release_lane[c]) state_next[c] = CH_IDLE;
        default:
          state_next[c] = CH_IDLE;
      endcase
    end
  end

  // A lane is never granted and released in the same cycle, so set/clear cannot collide.
  always_comb begin
    busy_next = busy_reg;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (grant[c])        busy_next = busy_next | pick_oh[c];
      if (release_lane[c]) busy_next[owner_reg[c]] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_reg <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        owner_reg[c] <= '0;
        addr_reg[c]  <= '0;
        wdata_reg[c] <= '0;
        rdata_reg[c] <= '0;
      end
    end else begin
      busy_reg <= busy_next;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (grant[c]) begin
          owner_reg[c] <= pick_idx[c];
          addr_reg[c]  <= grant_read[c]
                          ? consumer_read_address[pick_idx[c]*ADDR_BITS +: ADDR_BITS]
                          : consumer_write_address[pick_idx[c]*ADDR_BITS +: ADDR_BITS];
          wdata_reg[c] <= consumer_write_data[pick_idx[c]*DATA_BITS +: DATA_BITS];
        end
        if ((state_reg[c] == CH_READ_WAITING) && mem_read_ready[c])
          rdata_reg[c] <= mem_read_data[c*DATA_BITS +: DATA_BITS];
      end
    end
  end

  always_comb begin
    mem_read_valid       = '0;
    mem_write_valid      = '0;
    consumer_read_ready  = '0;
    consumer_write_ready = '0;
    consumer_read_data   = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      mem_read_valid[c]  = (state_reg[c] == CH_READ_WAITING);
      mem_write_valid[c] = (state_reg[c] == CH_WRITE_WAITING);
      if (state_reg[c] == CH_READ_RELAYING) begin
        consumer_read_ready[owner_reg[c]] = 1'b1;
        consumer_read_data[owner_reg[c]*DATA_BITS +: DATA_BITS] = rdata_reg[c];
      end
      if (state_reg[c] == CH_WRITE_RELAYING)
        consumer_write_ready[owner_reg[c]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Directed bench for mem_channel_arbiter: 8 lanes / 4 channels, plus a 1-channel instance for arbitration order.
module tb_mem_channel_arbiter;

  localparam int RD_LAT = 2;
  localparam int WR_LAT = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rv = '0, wv = '0, rrdy, wrdy;
  logic [63:0] raddr = '0, waddr = '0, wdat = '0, rdata;
  logic [3:0]  mrv, mrr = '0, mwv, mwr = '0;
  logic [31:0] mra, mrd = '0, mwa, mwd;

  logic [7:0]  r2_rv = '0, r2_wv = '0, r2_rrdy, r2_wrdy;
  logic [63:0] r2_raddr = '0, r2_waddr = '0, r2_wdat = '0, r2_rdata;
  logic [0:0]  m2_rv, m2_rr = '0, m2_wv, m2_wr = '0;
  logic [7:0]  m2_ra, m2_rd = '0, m2_wa, m2_wd;

  int checks = 0;
  int errors = 0;
  int rd_cnt [4];
  int wr_cnt [4];
  int rd2_cnt = 0;

  always #5 clk = ~clk;

  mem_channel_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(4)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rv), .consumer_read_address(raddr),
    .consumer_read_ready(rrdy), .consumer_read_data(rdata),
    .consumer_write_valid(wv), .consumer_write_address(waddr),
    .consumer_write_data(wdat), .consumer_write_ready(wrdy),
    .mem_read_valid(mrv), .mem_read_address(mra), .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa), .mem_write_data(mwd), .mem_write_ready(mwr)
  );

  mem_channel_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(1)) dut_one (
    .clk(clk), .reset(reset),
    .consumer_read_valid(r2_rv), .consumer_read_address(r2_raddr),
    .consumer_read_ready(r2_rrdy), .consumer_read_data(r2_rdata),
    .consumer_write_valid(r2_wv), .consumer_write_address(r2_waddr),
    .consumer_write_data(r2_wdat), .consumer_write_ready(r2_wrdy),
    .mem_read_valid(m2_rv), .mem_read_address(m2_ra), .mem_read_ready(m2_rr), .mem_read_data(m2_rd),
    .mem_write_valid(m2_wv), .mem_write_address(m2_wa), .mem_write_data(m2_wd), .mem_write_ready(m2_wr)
  );

  // Memory model: one-cycle ready pulse after a fixed latency; read data = address ^ 0xE7.
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (mrr[c]) mrr[c] = 1'b0;
      else if (mrv[c]) begin
        rd_cnt[c]++;
        if (rd_cnt[c] >= RD_LAT) begin
          mrr[c] = 1'b1;
          mrd[c*8 +: 8] = mra[c*8 +: 8] ^ 8'hE7;
          rd_cnt[c] = 0;
        end
      end else rd_cnt[c] = 0;
      if (mwr[c]) mwr[c] = 1'b0;
      else if (mwv[c]) begin
        wr_cnt[c]++;
        if (wr_cnt[c] >= WR_LAT) begin
          mwr[c] = 1'b1;
          wr_cnt[c] = 0;
        end
      end else wr_cnt[c] = 0;
    end
    if (m2_rr[0]) m2_rr[0] = 1'b0;
    else if (m2_rv[0]) begin
      m2_rr[0] = 1'b1;
      m2_rd = m2_ra ^ 8'hE7;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({mrv, mwv, rrdy, wrdy} !== '0) begin
      errors++;
      $display("FAIL reset_valids: got mrv=%b mwv=%b rrdy=%b wrdy=%b required all 0", mrv, mwv, rrdy, wrdy);
    end
    checks++;
    if ({rdata, mra, mwa, mwd, m2_rv, r2_rrdy} !== '0) begin
      errors++;
      $display("FAIL reset_data: got rdata=%h mra=%h mwa=%h mwd=%h m2_rv=%b r2_rrdy=%b required all 0",
               rdata, mra, mwa, mwd, m2_rv, r2_rrdy);
    end
    $display("reset: mrv=%b rrdy=%b rdata=%h", mrv, rrdy, rdata);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    int n;
    rv[3] = 1'b1;
    raddr[24 +: 8] = 8'h42;
    tick();
    checks++;
    if (mrv !== 4'b0001 || mra[7:0] !== 8'h42) begin
      errors++;
      $display("FAIL single_read_issue: got mrv=%b addr=%h required 0001 addr=42", mrv, mra[7:0]);
    end
    n = 0;
    while (!rrdy[3] && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 2 || rrdy !== 8'b0000_1000 || mrv !== 4'b0000) begin
      errors++;
      $display("FAIL single_read_latency: got cycles=%0d rrdy=%b mrv=%b required 2 00001000 0000", n, rrdy, mrv);
    end
    checks++;
    if (rdata[24 +: 8] !== 8'hA5) begin
      errors++;
      $display("FAIL single_read_data: got %h required a5", rdata[24 +: 8]);
    end
    tick();
    tick();
    checks++;
    if (rrdy[3] !== 1'b1 || rdata[24 +: 8] !== 8'hA5) begin
      errors++;
      $display("FAIL single_read_hold: got ready=%b data=%h required 1 a5", rrdy[3], rdata[24 +: 8]);
    end
    rv[3] = 1'b0;
    tick();
    checks++;
    if (rrdy !== 8'h00 || mrv !== 4'b0000) begin
      errors++;
      $display("FAIL single_read_release: got rrdy=%b mrv=%b required 0", rrdy, mrv);
    end
    $display("single_read: lane 3 addr 42 data %h after %0d cycles", rdata[24 +: 8], n);
  endtask

  task automatic test_read_priority();
    int n;
    rv[0] = 1'b1;  raddr[7:0] = 8'h20;
    wv[0] = 1'b1;  waddr[7:0] = 8'h30;  wdat[7:0] = 8'h99;
    tick();
    checks++;
    if (mrv !== 4'b0001 || mwv !== 4'b0000 || mra[7:0] !== 8'h20) begin
      errors++;
      $display("FAIL prio_read_first: got mrv=%b mwv=%b addr=%h required 0001 0000 20", mrv, mwv, mra[7:0]);
    end
    n = 0;
    while (!rrdy[0] && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (rdata[7:0] !== (8'h20 ^ 8'hE7)) begin
      errors++;
      $display("FAIL prio_read_data: got %h required %h", rdata[7:0], 8'h20 ^ 8'hE7);
    end
    rv[0] = 1'b0;
    tick();
    tick();
    checks++;
    if (mwv !== 4'b0001 || mrv !== 4'b0000 || mwa[7:0] !== 8'h30 || mwd[7:0] !== 8'h99) begin
      errors++;
      $display("FAIL prio_write_next: got mwv=%b mrv=%b addr=%h data=%h required 0001 0000 30 99",
               mwv, mrv, mwa[7:0], mwd[7:0]);
    end
    n = 0;
    while (!wrdy[0] && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (wrdy !== 8'h01) begin
      errors++;
      $display("FAIL prio_write_ready: got %b required 00000001", wrdy);
    end
    wv[0] = 1'b0;
    tick();
    checks++;
    if (wrdy !== 8'h00) begin
      errors++;
      $display("FAIL prio_write_release: got %b required 0", wrdy);
    end
    $display("read_priority: lane 0 read then write, write ready after %0d cycles", n);
  endtask

  task automatic test_write();
    wv[5] = 1'b1;
    waddr[40 +: 8] = 8'h10;
    wdat[40 +: 8] = 8'h7E;
    tick();
    checks++;
    if (mwv !== 4'b0001 || mwa[7:0] !== 8'h10 || mwd[7:0] !== 8'h7E) begin
      errors++;
      $display("FAIL write_issue: got mwv=%b addr=%h data=%h required 0001 10 7e", mwv, mwa[7:0], mwd[7:0]);
    end
    tick();
    checks++;
    if (wrdy !== 8'b0010_0000 || mwv !== 4'b0000) begin
      errors++;
      $display("FAIL write_ready: got wrdy=%b mwv=%b required 00100000 0000", wrdy, mwv);
    end
    tick();
    checks++;
    if (wrdy !== 8'b0010_0000) begin
      errors++;
      $display("FAIL write_hold: got %b required 00100000", wrdy);
    end
    wv[5] = 1'b0;
    tick();
    checks++;
    if (wrdy !== 8'h00) begin
      errors++;
      $display("FAIL write_release: got %b required 0", wrdy);
    end
    $display("write: lane 5 addr 10 data 7e accepted");
  endtask

  task automatic test_all_lanes();
    int n;
    int done;
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) begin
      rv[i] = 1'b1;
      raddr[i*8 +: 8] = 8'h80 + 8'(i);
    end
    tick();
    checks++;
    if (mrv !== 4'b1111 || mra !== 32'h8382_8180) begin
      errors++;
      $display("FAIL all_first_grant: got mrv=%b mra=%h required 1111 83828180", mrv, mra);
    end
    n = 0;
    done = 0;
    while (done < 8 && n < 200) begin
      tick();
      n++;
      for (int i = 0; i < 8; i++) begin
        if (rv[i] && rrdy[i]) begin
          exp = (8'h80 + 8'(i)) ^ 8'hE7;
          checks++;
          if (rdata[i*8 +: 8] !== exp) begin
            errors++;
            $display("FAIL all_lane_data lane %0d: got %h required %h", i, rdata[i*8 +: 8], exp);
          end
          $display("all_lanes: lane %0d done at cycle %0d data %h", i, n, rdata[i*8 +: 8]);
          rv[i] = 1'b0;
          done++;
        end
      end
    end
    checks++;
    if (done !== 8) begin
      errors++;
      $display("FAIL all_lanes_complete: got %0d lanes required 8", done);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    rv[2] = 1'b1;
    raddr[16 +: 8] = 8'h55;
    tick();
    checks++;
    if (mrv !== 4'b0001) begin
      errors++;
      $display("FAIL midreset_waiting: got mrv=%b required 0001", mrv);
    end
    reset = 1'b1;
    rv[2] = 1'b0;
    tick();
    checks++;
    if ({mrv, mwv, rrdy, wrdy, rdata, mra, mwa, mwd} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got mrv=%b rrdy=%b mra=%h rdata=%h required all 0", mrv, rrdy, mra, rdata);
    end
    reset = 1'b0;
    rv[6] = 1'b1;
    raddr[48 +: 8] = 8'h66;
    tick();
    checks++;
    if (mrv !== 4'b0001 || mra[7:0] !== 8'h66) begin
      errors++;
      $display("FAIL midreset_regrant: got mrv=%b addr=%h required 0001 66", mrv, mra[7:0]);
    end
    n = 0;
    while (!rrdy[6] && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (rrdy[6] !== 1'b1 || rdata[48 +: 8] !== 8'h81) begin
      errors++;
      $display("FAIL midreset_data: got ready=%b data=%h required 1 81", rrdy[6], rdata[48 +: 8]);
    end
    rv[6] = 1'b0;
    tick();
    $display("reset_mid: abandoned lane 2, lane 6 data %h", rdata[48 +: 8]);
  endtask

  task automatic test_arbitration_order();
    int n;
    int ng;
    logic prev;
    logic [7:0] grants [4];
    logic [7:0] exp;
    r2_raddr[7:0]  = 8'h00;
    r2_raddr[15:8] = 8'h01;
    r2_rv = 8'b0000_0011;
    prev = 1'b0;
    ng = 0;
    n = 0;
    while (ng < 4 && n < 100) begin
      tick();
      n++;
      if (m2_rv[0] && !prev) begin
        grants[ng] = m2_ra;
        $display("arbitration: grant %0d to lane %0d at cycle %0d", ng, m2_ra, n);
        ng++;
      end
      prev = m2_rv[0];
      for (int i = 0; i < 2; i++) begin
        if (r2_rv[i] && r2_rrdy[i]) r2_rv[i] = 1'b0;
        else if (!r2_rv[i])         r2_rv[i] = 1'b1;
      end
    end
    checks++;
    if (ng !== 4) begin
      errors++;
      $display("FAIL arb_grant_count: got %0d required 4", ng);
    end
    for (int k = 0; k < ng; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp = 8'(k % 2);
`else
      exp = 8'h00;
`endif
      checks++;
      if (grants[k] !== exp) begin
        errors++;
        $display("FAIL arb_grant_%0d: got lane %0d required lane %0d", k, grants[k], exp);
      end
    end
    r2_rv = '0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_read_priority();
    test_write();
    test_all_lanes();
    test_reset_mid();
    test_arbitration_order();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
